versatile_mem_ctrl_wb_arb: RTL

- Round-robin arbiter for the shared write port of the multi-queue egress FIFO in the Wishbone front end.
- Replaces the fixed-priority write-ack chain between Wishbone ports.
- Locks the grant to one port from the write command until the last data beat, so command and data words of a write burst enter the FIFO on consecutive grants.
- Read commands, which are single entries, never lock.

---
 rtl/versatile_mem_ctrl_wb_arb_pkg.sv | 33 +++
 rtl/versatile_mem_ctrl_wb_arb_if.sv | 24 ++
 rtl/versatile_mem_ctrl_rr_pick.sv | 46 ++++
 rtl/versatile_mem_ctrl_wb_arb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/versatile_mem_ctrl_wb_arb_pkg.sv
// Shared encodings and burst-length helper for the Wishbone egress FIFO write arbiter.
package versatile_mem_ctrl_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Data beats that follow a write command; anything but incrementing is a single beat.
    function automatic int unsigned burst_beats(input logic [2:0] cti,
                                                input logic [1:0] bte,
                                                input int unsigned linear_beats);
        if (cti == CTI_INC) begin
            case (bte)
                BTE_WRAP4:  return 4;
                BTE_WRAP8:  return 8;
                BTE_WRAP16: return 16;
                default:    return linear_beats;
            endcase
        end
        return 1;
    endfunction

endpackage

// File: rtl/versatile_mem_ctrl_wb_arb_if.sv
// Request/grant bundle between the Wishbone port queues and the FIFO write arbiter.
interface versatile_mem_ctrl_wb_arb_if #(
    parameter int unsigned NR_OF_PORTS = 3,
    parameter int unsigned IDX_W       = 2
);
    logic [NR_OF_PORTS-1:0]   req_i;
    logic [NR_OF_PORTS-1:0]   cmd_i;
    logic [NR_OF_PORTS-1:0]   we_i;
    logic [NR_OF_PORTS-1:0]   cyc_i;
    logic [3*NR_OF_PORTS-1:0] cti_i;
    logic [2*NR_OF_PORTS-1:0] bte_i;
    logic [NR_OF_PORTS-1:0]   gnt_o;
    logic [IDX_W-1:0]         gnt_idx_o;

    modport master (
        output req_i, cmd_i, we_i, cyc_i, cti_i, bte_i,
        input  gnt_o, gnt_idx_o
    );

    modport slave (
        input  req_i, cmd_i, we_i, cyc_i, cti_i, bte_i,
        output gnt_o, gnt_idx_o
    );
endinterface

// File: rtl/versatile_mem_ctrl_rr_pick.sv
// Round-robin pick: rotate requests to the pointer, take the lowest, rotate the index back.
module versatile_mem_ctrl_rr_pick #(
    parameter int unsigned NR_OF_PORTS = 3,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NR_OF_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NR_OF_PORTS-1:0] o_gnt,
    output logic [IDX_W-1:0]       o_idx
);
    localparam int unsigned SUM_W = IDX_W + 1;

    logic [NR_OF_PORTS-1:0] w_rot;
    logic [IDX_W-1:0]       w_off;
    logic                   w_any;

    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= SUM_W'(NR_OF_PORTS)) s = s - SUM_W'(NR_OF_PORTS);
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        w_rot = '0;
        w_off = '0;
        w_any = 1'b0;
        o_idx = '0;
        o_gnt = '0;
        for (int k = 0; k < NR_OF_PORTS; k++) begin
            w_rot[k] = i_req[add_mod(i_ptr, IDX_W'(k))];
        end
        for (int k = NR_OF_PORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = IDX_W'(k);
            end
        end
        if (w_any) o_idx = add_mod(i_ptr, w_off);
        for (int j = 0; j < NR_OF_PORTS; j++) begin
            o_gnt[j] = w_any && (o_idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/versatile_mem_ctrl_wb_arb.sv
// Round-robin write-port arbiter for the egress FIFO; locks the grant across a write burst.
// Optional lock-hold timeout with sticky timeout_o when ARB_TIMEOUT_EN is defined.
module versatile_mem_ctrl_wb_arb
    import versatile_mem_ctrl_pkg::*;
#(
    parameter int unsigned NR_OF_PORTS  = 3,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned LINEAR_BEATS = 16
`ifdef ARB_TIMEOUT_EN
   ,parameter int unsigned MAX_HOLD     = 64
`endif
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    versatile_mem_ctrl_wb_arb_if.slave bus,
    output logic                      lock_o,
    output logic [IDX_W-1:0]          owner_o
`ifdef ARB_TIMEOUT_EN
   ,output logic                      timeout_o
`endif
);
    localparam int unsigned MAX_BEATS = (LINEAR_BEATS > 16) ? LINEAR_BEATS : 16;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS) + 1;

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_owner;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_lock;

    logic [NR_OF_PORTS-1:0] w_pick_gnt;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [NR_OF_PORTS-1:0] w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_any;
    logic [IDX_W-1:0]       w_sel;
    logic [2:0]             w_cti;
    logic [1:0]             w_bte;
    logic                   w_rel_to;
    logic                   w_release;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (32'(idx) == NR_OF_PORTS - 1) ? '0 : idx + 1'b1;
    endfunction

    versatile_mem_ctrl_rr_pick #(
        .NR_OF_PORTS (NR_OF_PORTS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .i_req (bus.req_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    // Burst attributes come from the owner while locked, else from the fresh pick.
    assign w_sel = (r_state == LOCK) ? r_owner : w_pick_idx;
    assign w_cti = 3'(bus.cti_i >> (32'd3 * 32'(w_sel)));
    assign w_bte = 2'(bus.bte_i >> (32'd2 * 32'(w_sel)));

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        if (!wb_rst) begin
            if (r_state == ARB) begin
                w_gnt     = w_pick_gnt;
                w_gnt_idx = w_pick_idx;
            end else if (bus.req_i[r_owner] && bus.cyc_i[r_owner]) begin
                w_gnt[r_owner] = 1'b1;
                w_gnt_idx      = r_owner;
            end
        end
    end

    assign w_gnt_any     = |w_gnt;
    assign bus.gnt_o     = w_gnt;
    assign bus.gnt_idx_o = w_gnt_idx;

    assign w_release = (r_state == LOCK) &&
                       (!bus.cyc_i[r_owner] || w_rel_to ||
                        (w_gnt_any && (r_cnt == CNT_W'(1) || w_cti == CTI_EOB ||
                                       w_cti == CTI_CLASSIC)));

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_lock   <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_gnt_any) begin
                        if (bus.cmd_i[w_pick_idx] && bus.we_i[w_pick_idx]) begin
                            r_state <= LOCK;
                            r_lock  <= 1'b1;
                            r_owner <= w_pick_idx;
                            r_cnt   <= CNT_W'(burst_beats(w_cti, w_bte, LINEAR_BEATS));
                        end else begin
                            r_rr_ptr <= next_idx(w_pick_idx);
                        end
                    end
                end
                LOCK: begin
                    if (w_release) begin
                        r_state  <= ARB;
                        r_lock   <= 1'b0;
                        r_cnt    <= '0;
                        r_rr_ptr <= next_idx(r_owner);
                    end else if (w_gnt_any && r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign lock_o  = r_lock;
    assign owner_o = r_owner;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    assign w_rel_to = (r_state == LOCK) && bus.cyc_i[r_owner] && !w_gnt_any &&
                      (r_hold == HOLD_W'(MAX_HOLD - 1));

    // Counts consecutive stalled lock cycles; any owner grant restarts the count.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != LOCK || w_gnt_any || w_release) r_hold <= '0;
            else                                            r_hold <= r_hold + 1'b1;
            if (w_rel_to) r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_rel_to = 1'b0;
`endif

    a_no_grant_at_zero : assert property (@(posedge wb_clk) disable iff (wb_rst)
        !(r_state == LOCK && w_gnt_any && r_cnt == '0));

endmodule
